// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-subset CPU: req/ack instruction fetch, internal register file,
// FETCH/DECODE/EXEC/WB sequencing with a terminal HALT state and a writeback debug port.
module multicycle_cpu #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int IMEM_AW = 8,
  localparam int RA_W   = $clog2(REG_CNT)
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_data,
  output logic [IMEM_AW-1:0] pc,
  output logic               wb_valid,
  output logic [RA_W-1:0]    wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               halted,
  output logic               illegal
);

  // state  | meaning
  // FETCH  | imem_req held until ack; IR latched, pc advanced
  // DECODE | operands A/B read from the register file
  // EXEC   | ALU result latched; branches, jumps, halt and illegal resolved
  // WB     | register file written, wb_valid pulsed
  // HALT   | idle until reset
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  state_t              r_state;
  logic [IMEM_AW-1:0]  r_pc;
  logic [31:0]         r_ir;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_alu;
  logic [RA_W-1:0]     r_dst;
  logic                r_req;
  logic                r_wb_valid;
  logic [RA_W-1:0]     r_wb_addr;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_halted;
  logic                r_illegal;
  logic [DATA_W-1:0]   r_regs [REG_CNT];

  logic [5:0]          w_op;
  logic [5:0]          w_funct;
  logic [RA_W-1:0]     w_rs;
  logic [RA_W-1:0]     w_rt;
  logic [RA_W-1:0]     w_rd;
  logic [DATA_W-1:0]   w_simm;
  logic [IMEM_AW-1:0]  w_br_tgt;
  logic [DATA_W-1:0]   w_alu;
  logic [RA_W-1:0]     w_dst;
  logic                w_ill;
  logic                w_beq;
  logic                w_jmp;
  logic                w_hlt;

  assign w_op     = r_ir[31:26];
  assign w_funct  = r_ir[5:0];
  assign w_rs     = r_ir[21 +: RA_W];
  assign w_rt     = r_ir[16 +: RA_W];
  assign w_rd     = r_ir[11 +: RA_W];
  assign w_simm   = DATA_W'($signed(r_ir[15:0]));
  // pc already holds pc_ir + 1 once the instruction is in EXEC
  assign w_br_tgt = r_pc + IMEM_AW'($signed(r_ir[15:0]));

  always_comb begin
    w_alu = '0;
    w_dst = w_rd;
    w_ill = 1'b0;
    w_beq = 1'b0;
    w_jmp = 1'b0;
    w_hlt = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD:  w_alu = r_a + r_b;
          FN_SUB:  w_alu = r_a - r_b;
          FN_AND:  w_alu = r_a & r_b;
          FN_OR:   w_alu = r_a | r_b;
          FN_SLT:  w_alu = DATA_W'($signed(r_a) < $signed(r_b));
          default: w_ill = 1'b1;
        endcase
      end
      OP_ADDI: begin
        w_alu = r_a + w_simm;
        w_dst = w_rt;
      end
      OP_BEQ:  w_beq = 1'b1;
      OP_J:    w_jmp = 1'b1;
      OP_HALT: w_hlt = 1'b1;
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FETCH;
      r_pc       <= '0;
      r_ir       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_alu      <= '0;
      r_dst      <= '0;
      r_req      <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
      for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            r_req <= 1'b1;
          end else if (imem_ack) begin
            r_ir    <= imem_data;
            r_pc    <= r_pc + IMEM_AW'(1);
            r_req   <= 1'b0;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a     <= r_regs[w_rs];
          r_b     <= r_regs[w_rt];
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alu <= w_alu;
          r_dst <= w_dst;
          if (w_hlt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_ill || w_beq || w_jmp) begin
            if (w_ill) r_illegal <= 1'b1;
            if (w_beq && (r_a == r_b)) r_pc <= w_br_tgt;
            if (w_jmp) r_pc <= r_ir[IMEM_AW-1:0];
            r_req   <= 1'b1;
            r_state <= S_FETCH;
          end else begin
            // r0 writes still spend the WB cycle but stay invisible on the debug port
            if (w_dst != '0) begin
              r_wb_valid <= 1'b1;
              r_wb_addr  <= w_dst;
              r_wb_data  <= w_alu;
            end
            r_state <= S_WB;
          end
        end
        S_WB: begin
          if (r_dst != '0) r_regs[r_dst] <= r_alu;
          r_req   <= 1'b1;
          r_state <= S_FETCH;
        end
        S_HALT:  r_req <= 1'b0;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign wb_valid  = r_wb_valid;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: handshake, ALU/ADDI, branches/jumps, r0, overflow,
// illegal/halt, reset behaviour, plus a DATA_W=16 / REG_CNT=8 instance.
module tb_multicycle_cpu;

  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [5:0]  ADDI   = 6'b001000;
  localparam logic [5:0]  BEQ    = 6'b000100;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ill;
  } wb_t;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  addr;
  } fe_t;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [7:0]  pc;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        halted;
  logic        illegal;

  logic        imem_req2;
  logic [7:0]  imem_addr2;
  logic        imem_ack2;
  logic [31:0] imem_data2;
  logic [7:0]  pc2;
  logic        wb_valid2;
  logic [2:0]  wb_addr2;
  logic [15:0] wb_data2;
  logic        halted2;
  logic        illegal2;

  logic [31:0] mem [256];
  int unsigned cyc;
  int unsigned g_wait;
  int unsigned wcnt;
  int unsigned nfetch;
  wb_t         wb_q [$];
  fe_t         fe_q [$];
  int          n_chk;
  int          n_fail;
  logic [2:0]  cap2_addr;
  logic [15:0] cap2_data;
  int unsigned cap2_n;

  multicycle_cpu dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .pc(pc), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .halted(halted), .illegal(illegal)
  );

  multicycle_cpu #(.DATA_W(16), .REG_CNT(8), .IMEM_AW(8)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_data(imem_data2),
    .pc(pc2), .wb_valid(wb_valid2), .wb_addr(wb_addr2), .wb_data(wb_data2),
    .halted(halted2), .illegal(illegal2)
  );

  // small instance: zero-wait memory holding ADDI r7,r0,-1 then HALT
  assign imem_ack2  = imem_req2;
  assign imem_data2 = (imem_addr2 == 8'd0) ? 32'h2007_FFFF : HALT_W;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory model and monitors, all sampling on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      wcnt   = 0;
      nfetch = 0;
      fe_q.delete();
      wb_q.delete();
      imem_ack = 1'b0;
    end else begin
      if (wb_valid) wb_q.push_back('{cyc, wb_addr, wb_data, illegal});
      if (imem_req && (wcnt >= g_wait)) begin
        imem_ack  = 1'b1;
        imem_data = mem[imem_addr];
        wcnt      = 0;
        nfetch    = nfetch + 1;
        fe_q.push_back('{cyc, imem_addr});
      end else begin
        imem_ack = 1'b0;
        if (imem_req) wcnt = wcnt + 1;
      end
      if (wb_valid2) begin
        cap2_addr = wb_addr2;
        cap2_data = wb_data2;
        cap2_n    = cap2_n + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(input int t);
    return {6'b000010, 26'(t)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = HALT_W;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic start_run(input int unsigned w);
    g_wait = w;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_to_halt(input int budget, output int unsigned hcyc);
    hcyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) begin
        hcyc = cyc;
        break;
      end
    end
    chk("halt_reached", halted, 1);
  endtask

  int unsigned h;
  int          req_hi;
  int          exp_a [5];
  logic [31:0] exp_d [5];
  int          exp_f [8];

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_data = '0; g_wait = 5;
    n_chk = 0; n_fail = 0; cap2_n = 0; cap2_addr = '0; cap2_data = '0;

    // reset values, then 5 ack-less request cycles
    clear_mem();
    mem[0] = enc_i(ADDI, 0, 1, 5);
    repeat (3) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", pc, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    start_run(5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hs_req_addr", {imem_req, imem_addr}, 9'h100);
    end
    @(negedge clk);
    @(negedge clk);
    chk("hs_one_fetch", nfetch, 1);
    chk("hs_req_drop", imem_req, 0);
    chk("hs_pc", pc, 1);
    run_to_halt(100, h);
    chk("hs_wb_cnt", wb_q.size(), 1);
    if (wb_q.size() == 1) chk("hs_wb", {wb_q[0].addr, wb_q[0].data}, {5'd1, 32'd5});

    // ALU / ADDI sequence with zero-wait memory
    hold_reset();
    clear_mem();
    mem[0] = enc_i(ADDI, 0, 1, 5);
    mem[1] = enc_i(ADDI, 0, 2, -3);
    mem[2] = enc_r(1, 2, 3, 6'b100000);
    mem[3] = enc_r(2, 1, 4, 6'b100010);
    mem[4] = enc_r(2, 1, 5, 6'b101010);
    exp_a = '{1, 2, 3, 4, 5};
    exp_d = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFF8, 32'd1};
    start_run(0);
    run_to_halt(200, h);
    chk("alu_wb_cnt", wb_q.size(), 5);
    if (wb_q.size() == 5 && fe_q.size() == 6) begin
      for (int i = 0; i < 5; i++) begin
        chk("alu_wb_addr", wb_q[i].addr, exp_a[i]);
        chk("alu_wb_data", wb_q[i].data, exp_d[i]);
        if (i > 0) chk("alu_wb_spacing", wb_q[i].cyc - wb_q[i-1].cyc, 4);
      end
      // edges from the ack cycle to the observed event
      chk("alu_latency", wb_q[0].cyc - fe_q[0].cyc, 3);
      chk("halt_latency", h - fe_q[5].cyc, 3);
    end
    chk("alu_wb_hold", {wb_valid, wb_data}, {1'b0, 32'd1});
    chk("alu_halt_req", imem_req, 0);

    // branches and jumps, including pc wrap at 0xFF
    hold_reset();
    clear_mem();
    mem[0]   = enc_j(3);
    mem[3]   = enc_i(ADDI, 0, 1, 1);
    mem[4]   = enc_i(BEQ, 1, 0, 5);
    mem[5]   = enc_j(7);
    mem[7]   = enc_i(BEQ, 1, 1, 2);
    mem[10]  = enc_j(255);
    mem[255] = enc_i(BEQ, 0, 0, 1);
    exp_f = '{0, 3, 4, 5, 7, 10, 255, 1};
    start_run(0);
    run_to_halt(200, h);
    chk("br_fetch_cnt", fe_q.size(), 8);
    if (fe_q.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("br_fetch_addr", fe_q[i].addr, exp_f[i]);
      chk("j_latency", fe_q[1].cyc - fe_q[0].cyc, 3);
      chk("addi_spacing", fe_q[2].cyc - fe_q[1].cyc, 4);
      chk("beq_nt_latency", fe_q[3].cyc - fe_q[2].cyc, 3);
      chk("beq_t_latency", fe_q[5].cyc - fe_q[4].cyc, 3);
    end

    // r0 is immutable; signed overflow wraps
    hold_reset();
    clear_mem();
    mem[0] = enc_i(ADDI, 0, 0, 9);
    mem[1] = enc_r(0, 0, 6, 6'b100000);
    mem[2] = enc_i(ADDI, 0, 1, 16'h4000);
    for (int i = 3; i < 20; i++) mem[i] = enc_r(1, 1, 1, 6'b100000);
    mem[20] = enc_i(ADDI, 1, 2, -1);
    mem[21] = enc_i(ADDI, 0, 3, 1);
    mem[22] = enc_r(2, 3, 4, 6'b100000);
    start_run(0);
    run_to_halt(400, h);
    chk("r0_wb_cnt", wb_q.size(), 22);
    if (wb_q.size() == 22) begin
      chk("r0_read", {wb_q[0].addr, wb_q[0].data}, {5'd6, 32'd0});
      chk("ovf_max", {wb_q[19].addr, wb_q[19].data}, {5'd2, 32'h7FFF_FFFF});
      chk("ovf_add", {wb_q[21].addr, wb_q[21].data}, {5'd4, 32'h8000_0000});
    end

    // illegal instruction continues; HALT is sticky until reset
    hold_reset();
    clear_mem();
    mem[0] = enc_i(ADDI, 0, 1, 7);
    mem[1] = {6'b010101, 5'd0, 5'd2, 16'd1};
    mem[2] = enc_i(ADDI, 0, 3, 11);
    start_run(0);
    run_to_halt(200, h);
    chk("ill_wb_cnt", wb_q.size(), 2);
    if (wb_q.size() == 2) begin
      chk("ill_before", wb_q[0].ill, 0);
      chk("ill_after", {wb_q[1].ill, wb_q[1].addr, wb_q[1].data}, {1'b1, 5'd3, 32'd11});
    end
    req_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) req_hi++;
    end
    chk("halt_req_low", req_hi, 0);
    chk("halt_sticky", {halted, illegal, pc}, {1'b1, 1'b1, 8'd4});
    rst = 1'b0;
    #1;
    chk("rst_clears", {halted, illegal, pc, imem_req}, {1'b0, 1'b0, 8'd0, 1'b0});

    // asynchronous reset during an outstanding fetch
    start_run(3);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_req_before", imem_req, 1);
    rst = 1'b0;
    #1;
    chk("midrst_req_after", {imem_req, pc}, {1'b0, 8'd0});

    // DATA_W=16, REG_CNT=8 instance ran alongside every phase
    chk("p16_seen", cap2_n != 0, 1);
    chk("p16_wb", {cap2_addr, cap2_data}, {3'd7, 16'hFFFF});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_cpu.md
# multicycle_cpu

Parametrised multi-cycle successor to the single-cycle MIPS-subset datapath. It fetches 32-bit instructions over a req/ack handshake from an external instruction memory, then decodes, executes and writes back through an internal register file. Each instruction is sequenced by a four-state controller plus a terminal HALT state. It exposes a writeback debug port (address/data/valid) for the bench and for the top level.

## Interface
- DATA_W, 32: datapath and register width; legal range 16..64.
- REG_CNT, 32: number of registers; power of two, 2..32. Register index width RA_W = log2(REG_CNT); instruction register fields are truncated to RA_W bits.
- IMEM_AW, 8: instruction word-address width. The PC is a word address with no byte/4 division.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  IMEM_AW  word address of the fetch; equals pc
- imem_ack  in  1  memory response valid; ignored while imem_req=0
- imem_data  in  32  instruction; sampled in the ack cycle
- pc  out  IMEM_AW  current program counter
- wb_valid  out  1  one-cycle pulse for each architectural register write
- wb_addr  out  RA_W  destination register of the write
- wb_data  out  DATA_W  value written
- halted  out  1  high from entry into HALT until reset
- illegal  out  1  sticky flag; set by any undecodable instruction

## Operation
- Encoding follows MIPS32 fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], target[25:0].
- R-type (op 000000), result to rd:
  - funct 100000 ADD
  - funct 100010 SUB
  - funct 100100 AND
  - funct 100101 OR
  - funct 101010 SLT (signed; result 1 or 0)
- I-type and jumps:
  - ADDI (001000): rt = rs + sext(imm).
  - BEQ (000100): if rs == rt, pc_next = pc_ir + 1 + sext(imm), where pc_ir is the address of the branch.
  - J (000010): pc = target[IMEM_AW-1:0].
  - HALT (111111): stop execution.
- Any other op/funct combination: no register write, illegal is set, execution continues at the next instruction.
- Arithmetic wraps modulo 2^DATA_W and sign-extension is to DATA_W bits. PC arithmetic wraps modulo 2^IMEM_AW.
- Register 0 always reads 0. Writes to register 0 are discarded, and wb_valid is not pulsed for them.
- State machine:
  - FETCH: imem_req=1. On imem_ack, latch IR, pc <= pc+1, go to DECODE. Otherwise stay in FETCH, holding req and addr stable.
  - DECODE: latch A = reg[rs] and B = reg[rt], go to EXEC.
  - EXEC: ALU computes and latches the result.
    - BEQ taken: pc <= pc_ir + 1 + sext(imm), go to FETCH.
    - BEQ not taken: go to FETCH.
    - J: load pc, go to FETCH.
    - HALT: go to HALT.
    - Illegal instruction: set illegal, go to FETCH.
    - Otherwise: go to WB.
  - WB: write the register file; wb_valid=1 with wb_addr/wb_data; go to FETCH.
  - HALT: imem_req=0 and halted=1, permanently until reset.

## Timing
- Reset values: state FETCH, pc 0, all registers 0, imem_req 0, wb_valid 0, wb_addr 0, wb_data 0, halted 0, illegal 0.
- imem_req rises on the first clock edge after rst is released.
- Reset asserted mid-operation drops imem_req immediately (asynchronously) and discards any in-flight instruction.
- Zero-wait memory (ack in the first req cycle) gives these latencies:
  - ALU and ADDI: 4 cycles.
  - BEQ and J: 3 cycles.
  - HALT: 3 cycles to halted=1.
- Each wait cycle adds one cycle. imem_req deasserts in the cycle after ack.
- A register written in WB is visible to the next instruction's DECODE, so no forwarding or hazards exist.
- wb_data and wb_addr hold their last values between pulses.

## Test plan
- Reset/ack handshake: hold rst low, check all outputs are 0. Release rst with imem_ack tied 0 for 5 cycles, then 1. Check imem_req stays high with imem_addr=0 throughout, and one instruction is fetched.
- ALU and ADDI sequence:
  - ADDI r1,r0,5 → wb r1=5.
  - ADDI r2,r0,-3 → wb r2=0xFFFFFFFD.
  - ADD r3,r1,r2 → wb r3=2.
  - SUB r4,r2,r1 → wb r4=0xFFFFFFF8.
  - SLT r5,r2,r1 → wb r5=1.
  - Each wb_valid pulse is exactly 4 cycles apart.
- Branch and jump:
  - BEQ r1,r1,+2 at address 7 → next imem_addr=10.
  - BEQ r1,r0 (not taken) → next imem_addr=pc_ir+1.
  - J to target 0x3 → imem_addr=3.
  - BEQ at 0xFF with imm=+1 at IMEM_AW=8 → wraps to next imem_addr=0x01.
- r0 and overflow: ADDI r0,r0,9 gives no wb_valid and a later read of r0 returns 0. ADD of 0x7FFFFFFF+1 gives 0x80000000.
- Illegal and halt: op 010101 sets illegal with no writeback, and execution continues. HALT then gives halted=1 and imem_req=0 forever. Asserting rst then clears halted, illegal and pc.
- Parameter sweep: DATA_W=16, REG_CNT=8. ADDI r7,r0,-1 → wb_addr=7, wb_data=0xFFFF.
